// File: rtl/vend_pkg.sv
// Shared types, default coin values and width helper for the vending controller.
package vend_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      VEND   = 2'd1,
      PAYOUT = 2'd2
   } vend_state_e;

   localparam int unsigned DEF_PRICE  = 5;
   localparam int unsigned DEF_COIN_A = 1;
   localparam int unsigned DEF_COIN_B = 2;
   localparam int unsigned DEF_COIN_C = 5;
   localparam int unsigned DEF_CHG_HI = 2;
   localparam int unsigned DEF_CW     = 6;

   // Bits needed to hold the largest credit+coin sum seen before a vend.
   function automatic int unsigned min_cw(input int unsigned price,
                                          input int unsigned coin_a,
                                          input int unsigned coin_b,
                                          input int unsigned coin_c);
      int unsigned mx;
      int unsigned top;
      int unsigned w;
      mx = coin_a;
      if (coin_b > mx) mx = coin_b;
      if (coin_c > mx) mx = coin_c;
      top = price - 1 + mx;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((top >> i) != 0) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin/cancel inputs and dispenser/hopper/credit outputs of the vending controller.
interface vend_fsm_param_if
   import vend_pkg::*;
#(
   parameter int unsigned CW = DEF_CW
);
   logic          in_a;
   logic          in_b;
   logic          in_c;
   logic          cancel;
   logic          vend;
   logic          chg_hi;
   logic          chg_lo;
   logic          coin_rej;
   logic          busy;
   logic [CW-1:0] credit;

   modport master (
      output in_a, in_b, in_c, cancel,
      input  vend, chg_hi, chg_lo, coin_rej, busy, credit
   );

   modport slave (
      input  in_a, in_b, in_c, cancel,
      output vend, chg_hi, chg_lo, coin_rej, busy, credit
   );
endinterface

// File: rtl/change_payout.sv
// Serial change emitter: loaded with an amount on start, emits one coin per cycle,
// largest coin first, with done marking the final coin.
module change_payout
   import vend_pkg::*;
#(
   parameter int unsigned CW     = DEF_CW,
   parameter int unsigned CHG_HI = DEF_CHG_HI
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] amount,
   output logic          chg_hi,
   output logic          chg_lo,
   output logic          done
);

   logic [CW-1:0] rem;
   logic [CW-1:0] rem_d;
   logic [CW-1:0] src_c;
   logic          act_c;
   logic          hi_c;

   // The first coin goes out on the same edge that loads the amount.
   always_comb begin
      src_c = start ? amount : rem;
      act_c = start || (rem != '0);
      hi_c  = src_c >= CW'(CHG_HI);
      rem_d = rem;
      if (act_c) rem_d = hi_c ? (src_c - CW'(CHG_HI)) : (src_c - CW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem    <= '0;
         chg_hi <= 1'b0;
         chg_lo <= 1'b0;
         done   <= 1'b0;
      end else begin
         rem    <= rem_d;
         chg_hi <= act_c && hi_c;
         chg_lo <= act_c && !hi_c;
         done   <= act_c && (rem_d == '0);
      end
   end

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: accumulates coin credit, vends at PRICE and
// pays change or refunds serially through change_payout.
module vend_fsm_param
   import vend_pkg::*;
#(
   parameter int unsigned PRICE  = DEF_PRICE,
   parameter int unsigned COIN_A = DEF_COIN_A,
   parameter int unsigned COIN_B = DEF_COIN_B,
   parameter int unsigned COIN_C = DEF_COIN_C,
   parameter int unsigned CHG_HI = DEF_CHG_HI,
   parameter int unsigned CW     = DEF_CW
) (
   input logic             clk,
   input logic             rst,
   vend_fsm_param_if.slave bus
);

   localparam logic [1:0] S_ACCUM  = ACCUM;
   localparam logic [1:0] S_VEND   = VEND;
   localparam logic [1:0] S_PAYOUT = PAYOUT;

   if (CW < min_cw(PRICE, COIN_A, COIN_B, COIN_C)) begin : g_cw_chk
      $error("vend_fsm_param: CW too small for PRICE and coin values");
   end
   if (PRICE < 1 || PRICE > 31) begin : g_price_chk
      $error("vend_fsm_param: PRICE out of range 1..31");
   end

   logic [1:0]    state;
   logic [1:0]    state_d;
   logic [CW-1:0] credit_q;
   logic [CW-1:0] credit_d;
   logic [CW-1:0] rem_q;
   logic [CW-1:0] rem_d;
   logic [CW-1:0] val_c;
   logic [CW-1:0] sum_c;
   logic [CW-1:0] amount_c;
   logic          start_c;
   logic          coin_c;
   logic          vend_q;
   logic          busy_q;
   logic          rej_q;
   logic          pay_hi;
   logic          pay_lo;
   logic          pay_done;

   always_comb begin
      state_d  = state;
      credit_d = credit_q;
      rem_d    = rem_q;
      start_c  = 1'b0;
      amount_c = '0;
      coin_c   = bus.in_a | bus.in_b | bus.in_c;
      val_c    = bus.in_c ? CW'(COIN_C) : (bus.in_b ? CW'(COIN_B) : CW'(COIN_A));
      sum_c    = credit_q + val_c;
      case (state)
         S_ACCUM: begin
            // Cancel outranks every coin, even when there is nothing to refund.
            if (bus.cancel) begin
               if (credit_q != '0) begin
                  start_c  = 1'b1;
                  amount_c = credit_q;
                  credit_d = '0;
                  state_d  = S_PAYOUT;
               end
            end else if (coin_c) begin
               if (sum_c < CW'(PRICE)) begin
                  credit_d = sum_c;
               end else begin
                  rem_d    = sum_c - CW'(PRICE);
                  credit_d = '0;
                  state_d  = S_VEND;
               end
            end
         end
         S_VEND: begin
            rem_d = '0;
            if (rem_q != '0) begin
               start_c  = 1'b1;
               amount_c = rem_q;
               state_d  = S_PAYOUT;
            end else begin
               state_d = S_ACCUM;
            end
         end
         S_PAYOUT: begin
            if (pay_done) state_d = S_ACCUM;
         end
         default: state_d = S_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_ACCUM;
         credit_q <= '0;
         rem_q    <= '0;
         vend_q   <= 1'b0;
         busy_q   <= 1'b0;
         rej_q    <= 1'b0;
      end else begin
         state    <= state_d;
         credit_q <= credit_d;
         rem_q    <= rem_d;
         vend_q   <= (state_d == S_VEND);
         busy_q   <= (state_d != S_ACCUM);
         rej_q    <= (state != S_ACCUM) && coin_c;
      end
   end

   change_payout #(
      .CW     (CW),
      .CHG_HI (CHG_HI)
   ) u_payout (
      .clk    (clk),
      .rst    (rst),
      .start  (start_c),
      .amount (amount_c),
      .chg_hi (pay_hi),
      .chg_lo (pay_lo),
      .done   (pay_done)
   );

   assign bus.vend     = vend_q;
   assign bus.busy     = busy_q;
   assign bus.coin_rej = rej_q;
   assign bus.credit   = credit_q;
   assign bus.chg_hi   = pay_hi;
   assign bus.chg_lo   = pay_lo;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: two instances (PRICE=5/COIN_C=5 and PRICE=7/COIN_C=10)
// share the same stimulus and are checked every cycle against a credit/coin-count model.
module tb_vend_fsm_param;

   logic clk = 1'b0;
   logic rst, a, b, c, x;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   vend_fsm_param_if #(.CW(6)) bus0 ();
   vend_fsm_param_if #(.CW(6)) bus1 ();

   assign bus0.in_a = a;  assign bus0.in_b = b;  assign bus0.in_c = c;  assign bus0.cancel = x;
   assign bus1.in_a = a;  assign bus1.in_b = b;  assign bus1.in_c = c;  assign bus1.cancel = x;

   vend_fsm_param #(.PRICE(5), .COIN_A(1), .COIN_B(2), .COIN_C(5), .CHG_HI(2), .CW(6))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   vend_fsm_param #(.PRICE(7), .COIN_A(1), .COIN_B(2), .COIN_C(10), .CHG_HI(2), .CW(6))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Model: credit plus counts of pending vend / large / small coins, drained one per cycle.
   int p_price [2] = '{5, 7};
   int p_ca    [2] = '{1, 1};
   int p_cb    [2] = '{2, 2};
   int p_cc    [2] = '{5, 10};
   int p_hi    [2] = '{2, 2};
   int m_credit[2], m_nhi[2], m_nlo[2];
   bit m_vend  [2];
   bit e_vend[2], e_hi[2], e_lo[2], e_busy[2], e_rej[2];

   task automatic queue_change(input int k, input int amt);
      m_nhi[k] = amt / p_hi[k];
      m_nlo[k] = amt % p_hi[k];
   endtask

   task automatic model_step(input int k);
      int v, sum;
      if (rst) begin
         m_credit[k] = 0; m_nhi[k] = 0; m_nlo[k] = 0; m_vend[k] = 0;
         e_vend[k] = 0; e_hi[k] = 0; e_lo[k] = 0; e_busy[k] = 0; e_rej[k] = 0;
         return;
      end
      e_rej[k] = e_busy[k] && (a || b || c);
      if (!e_busy[k]) begin
         if (x) begin
            if (m_credit[k] > 0) begin
               queue_change(k, m_credit[k]);
               m_credit[k] = 0;
            end
         end else if (a || b || c) begin
            v   = c ? p_cc[k] : (b ? p_cb[k] : p_ca[k]);
            sum = m_credit[k] + v;
            if (sum < p_price[k]) m_credit[k] = sum;
            else begin
               m_credit[k] = 0;
               m_vend[k]   = 1;
               queue_change(k, sum - p_price[k]);
            end
         end
      end
      e_vend[k] = 0; e_hi[k] = 0; e_lo[k] = 0;
      if (m_vend[k]) begin e_vend[k] = 1; m_vend[k] = 0; end
      else if (m_nhi[k] > 0) begin e_hi[k] = 1; m_nhi[k]--; end
      else if (m_nlo[k] > 0) begin e_lo[k] = 1; m_nlo[k]--; end
      e_busy[k] = e_vend[k] | e_hi[k] | e_lo[k];
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
   end

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_dut(input int k, input logic vd, input logic hi, input logic lo,
                          input logic rj, input logic bz, input logic [5:0] cr);
      check($sformatf("vend%0d", k),     int'(vd), int'(e_vend[k]));
      check($sformatf("chg_hi%0d", k),   int'(hi), int'(e_hi[k]));
      check($sformatf("chg_lo%0d", k),   int'(lo), int'(e_lo[k]));
      check($sformatf("coin_rej%0d", k), int'(rj), int'(e_rej[k]));
      check($sformatf("busy%0d", k),     int'(bz), int'(e_busy[k]));
      check($sformatf("credit%0d", k),   int'(cr), m_credit[k]);
   endtask

   always @(posedge clk) begin
      #2;
      cmp_dut(0, bus0.vend, bus0.chg_hi, bus0.chg_lo, bus0.coin_rej, bus0.busy, bus0.credit);
      cmp_dut(1, bus1.vend, bus1.chg_hi, bus1.chg_lo, bus1.coin_rej, bus1.busy, bus1.credit);
   end

   // Stimulus word: {rst, cancel, in_c, in_b, in_a}; returns #3 into the cycle it causes.
   localparam logic [4:0] N = 5'b00000, A = 5'b00001, B = 5'b00010, C = 5'b00100,
                          X = 5'b01000, R = 5'b10000;

   task automatic cyc(input logic [4:0] v);
      @(negedge clk);
      {rst, x, c, b, a} = v;
      @(posedge clk);
      #3;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(N);
   endtask

   initial begin
      {rst, x, c, b, a} = 5'b10000;
      cyc(R); cyc(R);
      cyc(N);
      check("rst_credit0", int'(bus0.credit), 0);
      check("rst_busy0",   int'(bus0.busy), 0);
      check("rst_vend1",   int'(bus1.vend), 0);

      // 4 + 5 at price 5: vend then two large coins
      cyc(A); cyc(A); cyc(A); cyc(A);
      check("s1_credit4", int'(bus0.credit), 4);
      cyc(C);
      check("s1_vend", int'(bus0.vend), 1);
      check("s1_busy", int'(bus0.busy), 1);
      cyc(N); check("s1_hi1", int'(bus0.chg_hi), 1);
      cyc(N); check("s1_hi2", int'(bus0.chg_hi), 1);
      cyc(N); check("s1_idle", int'(bus0.busy), 0);
      check("s1_credit", int'(bus0.credit), 0);
      idle(8);

      // exact price, no change; then cancel at credit 0 does nothing on dut0
      cyc(B); cyc(B); cyc(A);
      check("s2_vend", int'(bus0.vend), 1);
      cyc(N);
      check("s2_nochg", int'(bus0.chg_hi | bus0.chg_lo), 0);
      check("s2_credit", int'(bus0.credit), 0);
      cyc(X);
      check("s4_cancel0", int'(bus0.busy | bus0.chg_hi | bus0.chg_lo), 0);
      idle(8);

      // refund of 3
      cyc(B); cyc(A); cyc(X);
      check("s3_hi", int'(bus0.chg_hi), 1);
      check("s3_novend", int'(bus0.vend), 0);
      cyc(N); check("s3_lo", int'(bus0.chg_lo), 1);
      cyc(N); check("s3_done", int'(bus0.busy), 0);
      idle(6);

      // in_a and in_c together: only 5 counted
      cyc(A | C);
      check("s4_vend", int'(bus0.vend), 1);
      cyc(N);
      check("s4_nochg", int'(bus0.chg_hi | bus0.chg_lo), 0);
      idle(8);

      // coin during payout is rejected and not credited
      cyc(A); cyc(A); cyc(A); cyc(A); cyc(C);
      cyc(N); cyc(B);
      check("s5_rej", int'(bus0.coin_rej), 1);
      cyc(N);
      check("s5_credit", int'(bus0.credit), 0);
      idle(8);

      // reset during the first change coin abandons the payout
      cyc(A); cyc(A); cyc(A); cyc(A); cyc(C);
      cyc(N); check("s6_hi", int'(bus0.chg_hi), 1);
      cyc(R);
      check("s6_rst_hi", int'(bus0.chg_hi), 0);
      check("s6_rst_busy", int'(bus0.busy), 0);
      cyc(N); cyc(N);
      check("s6_nochg", int'(bus0.chg_hi | bus0.chg_lo), 0);
      idle(4);

      // price 7, coin C = 10: credit 6 + 10 gives vend then 9 in change
      cyc(R);
      for (int i = 0; i < 6; i++) cyc(A);
      check("s7_credit6", int'(bus1.credit), 6);
      cyc(C);
      check("s7_vend", int'(bus1.vend), 1);
      for (int i = 0; i < 4; i++) begin
         cyc(N); check("s7_hi", int'(bus1.chg_hi), 1);
      end
      cyc(N); check("s7_lo", int'(bus1.chg_lo), 1);
      cyc(N); check("s7_done", int'(bus1.busy), 0);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
